// File: rtl/multi_line_animator.sv
// multi_line_animator: animates N_LINES parallel lines, erasing and redrawing them one step further per update
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   update_event  one-cycle request to advance the animation
//   pause         while high, an erase is not started from HOLD
//   x, y          pixel coordinates, meaningful when pixel_valid is high
//   pixel_color   1 draws white, 0 erases black
//   pixel_valid   (x, y, pixel_color) is a pixel to write this cycle
//   frame_done    pulse on the last pixel of the last drawn line
//   step          current animation position
// line_drawer: Bresenham rasteriser; reset loads the endpoints, then one pixel per cycle until (x1, y1)
module line_drawer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x0_i,
    input  logic [W-1:0] y0_i,
    input  logic [W-1:0] x1_i,
    input  logic [W-1:0] y1_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o
);
    localparam int E = W + 3;
    logic [W-1:0] x_q, x_d, y_q, y_d, x1_q, y1_q;
    logic signed [E-1:0] dx_q, dy_q, err_q, err_d;
    logic signed [E-1:0] ddx, ddy, adx, ady, e2;
    logic sx_q, sy_q, step_x, step_y, done;
    always_comb begin
        ddx = $signed(E'(x1_i)) - $signed(E'(x0_i));
        ddy = $signed(E'(y1_i)) - $signed(E'(y0_i));
        adx = ddx < 0 ? -ddx : ddx;
        ady = ddy < 0 ? -ddy : ddy;
        e2 = err_q <<< 1;
        done = x_q == x1_q && y_q == y1_q;
        step_x = !done && e2 >= dy_q;
        step_y = !done && e2 <= dx_q;
        x_d = step_x ? (sx_q ? x_q - W'(1) : x_q + W'(1)) : x_q;
        y_d = step_y ? (sy_q ? y_q - W'(1) : y_q + W'(1)) : y_q;
        err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= x0_i;
            y_q   <= y0_i;
            x1_q  <= x1_i;
            y1_q  <= y1_i;
            dx_q  <= adx;
            dy_q  <= -ady;
            err_q <= adx - ady;
            sx_q  <= ddx < 0;
            sy_q  <= ddy < 0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            err_q <= err_d;
        end
    end
    assign x_o = x_q;
    assign y_o = y_q;
endmodule

module multi_line_animator #(
    parameter int W            = 11,
    parameter int N_LINES      = 2,
    parameter int LINE_SPACING = 20,
    parameter int LEN_X        = 10,
    parameter int LEN_Y        = 15,
    parameter int STEPS        = 128,
    parameter int BOUNCE       = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         update_event,
    input  logic         pause,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         pixel_color,
    output logic         pixel_valid,
    output logic         frame_done,
    output logic [W-1:0] step
);
    localparam int LW = N_LINES > 1 ? $clog2(N_LINES) : 1;
    typedef enum logic [2:0] {LOAD_DRAW, DRAW, HOLD, LOAD_ERASE, ERASE} state_t;
    state_t state_q, state_d;
    logic [W-1:0] step_q, step_d, x0, y0, x1, y1;
    logic [LW-1:0] line_q, line_d;
    logic dir_q, dir_d, pending_q, pending_d;
    logic active, complete, last_line, turn;
    assign x0 = step_q;
    assign y0 = step_q + W'(int'(line_q) * LINE_SPACING);
    assign x1 = x0 + W'(LEN_X);
    assign y1 = y0 + W'(LEN_Y);
    assign last_line = line_q == LW'(N_LINES - 1);
    assign active = state_q == DRAW || state_q == ERASE;
    assign complete = active && x == x1 && y == y1;
    assign pixel_valid = active && !reset;
    assign pixel_color = state_q == DRAW && !reset;
    assign frame_done = state_q == DRAW && complete && last_line && !reset;
    assign step = step_q;
    // dir_q=1 means stepping down; turn marks the reversal point in ping-pong mode
    assign turn = dir_q ? step_q == '0 : step_q == W'(STEPS - 1);
    line_drawer #(.W(W)) u_drawer (
        .clk  (clk),
        .reset(reset || state_q == LOAD_DRAW || state_q == LOAD_ERASE),
        .x0_i (x0),
        .y0_i (y0),
        .x1_i (x1),
        .y1_i (y1),
        .x_o  (x),
        .y_o  (y)
    );
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        line_d    = line_q;
        dir_d     = dir_q;
        pending_d = pending_q | update_event;
        case (state_q)
            LOAD_DRAW:  state_d = DRAW;
            LOAD_ERASE: state_d = ERASE;
            DRAW: if (complete) begin
                line_d  = last_line ? '0 : line_q + LW'(1);
                state_d = last_line ? HOLD : LOAD_DRAW;
            end
            HOLD: if ((update_event || pending_q) && !pause) begin
                pending_d = 1'b0;
                state_d   = LOAD_ERASE;
            end
            ERASE: if (complete) begin
                line_d  = last_line ? '0 : line_q + LW'(1);
                state_d = last_line ? LOAD_DRAW : LOAD_ERASE;
                if (last_line) begin
                    dir_d  = BOUNCE != 0 && (dir_q ^ turn);
                    step_d = BOUNCE != 0 ? (dir_d ? step_q - W'(1) : step_q + W'(1))
                                         : (turn ? '0 : step_q + W'(1));
                end
            end
            default: state_d = LOAD_DRAW;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD_DRAW;
            step_q    <= '0;
            line_q    <= '0;
            dir_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            line_q    <= line_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_multi_line_animator.sv
// tb_multi_line_animator: scoreboard bench for multi_line_animator plus two small-STEPS instances for step sequencing
module tb_multi_line_animator;
    localparam int W = 11;
    typedef struct {
        int   x0;
        int   y0;
        int   i;
        logic color;
        logic fd;
    } pix_t;
    logic clk = 0, reset = 1, update_event = 0, pause = 0, upd_b = 0, upd_w = 0;
    logic [W-1:0] x, y, step, xb, yb, stepb, xw, yw, stepw;
    logic pc, pv, fd, pcb, pvb, fdb, pcw, pvw, fdw;
    int total = 0, bad = 0;
    int a, d;
    pix_t q[$];
    pix_t e;
    int exp_b[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int exp_w[4] = '{1, 2, 3, 0};

    always #5 clk = ~clk;

    multi_line_animator dut (
        .clk(clk), .reset(reset), .update_event(update_event), .pause(pause),
        .x(x), .y(y), .pixel_color(pc), .pixel_valid(pv), .frame_done(fd), .step(step)
    );
    multi_line_animator #(.N_LINES(1), .STEPS(4), .BOUNCE(1)) dut_b (
        .clk(clk), .reset(reset), .update_event(upd_b), .pause(1'b0),
        .x(xb), .y(yb), .pixel_color(pcb), .pixel_valid(pvb), .frame_done(fdb), .step(stepb)
    );
    multi_line_animator #(.N_LINES(1), .STEPS(4), .BOUNCE(0)) dut_w (
        .clk(clk), .reset(reset), .update_event(upd_w), .pause(1'b0),
        .x(xw), .y(yw), .pixel_color(pcw), .pixel_valid(pvw), .frame_done(fdw), .step(stepw)
    );

    // Each emitted pixel must match the next expected one: exact y, exact colour and frame_done,
    // and x within half a pixel of the ideal line x0 + i*10/15.
    always @(negedge clk) begin
        total++;
        if (pv) begin
            if (q.size() == 0) begin
                bad++;
                $display("FAIL pixel: got unexpected pixel (%0d,%0d) color=%0d, required no pixel", x, y, pc);
            end else begin
                e = q.pop_front();
                a = int'(x) - e.x0;
                d = 15 * a - 10 * e.i;
                if (pc !== e.color || int'(y) != e.y0 + e.i || d > 7 || d < -7 || fd !== e.fd) begin
                    bad++;
                    $display("FAIL pixel: got (%0d,%0d) color=%0d fd=%0d, required y=%0d x~%0d+%0d*10/15 color=%0d fd=%0d",
                             x, y, pc, fd, e.y0 + e.i, e.x0, e.i, e.color, e.fd);
                end
            end
        end else if (fd !== 1'b0) begin
            bad++;
            $display("FAIL frame_done_idle: got %0d without a pixel, required 0", fd);
        end
    end

    task automatic push_frame(input int s, input logic color);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                pix_t p;
                p.x0 = s;
                p.y0 = s + 20 * k;
                p.i = i;
                p.color = color;
                p.fd = color && k == 1 && i == 15;
                q.push_back(p);
            end
    endtask

    task automatic pulse(input int which);
        @(posedge clk) #1;
        if (which == 0) update_event = 1; else if (which == 1) upd_b = 1; else upd_w = 1;
        @(posedge clk) #1;
        update_event = 0; upd_b = 0; upd_w = 0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 3000 && q.size() != 0; n++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pixels outstanding, required 0", name, q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_step(input string name, input int want);
        total++;
        if (int'(step) != want) begin
            bad++;
            $display("FAIL %s_step: got %0d, required %0d", name, step, want);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (pv !== 0 || pc !== 0 || fd !== 0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%0d color=%0d fd=%0d, required 0 0 0", pv, pc, fd);
        end
        check_step("reset", 0);
        push_frame(0, 1);
        @(posedge clk) #1 reset = 0;
        wait_drain("first_frame");
        repeat (30) @(negedge clk);
        total++;
        if (pv !== 0) begin
            bad++;
            $display("FAIL hold_idle: got valid=%0d, required 0", pv);
        end
        check_step("hold", 0);
    endtask

    task automatic test_update();
        push_frame(0, 0);
        push_frame(1, 1);
        pulse(0);
        wait_drain("update");
        check_step("update", 1);
    endtask

    task automatic test_pending();
        int n;
        push_frame(1, 0); push_frame(2, 1); push_frame(2, 0); push_frame(3, 1);
        pulse(0);
        n = 0;
        while (!(pv && pc) && n < 200) begin @(negedge clk); n++; end
        total++;
        if (!(pv && pc)) begin
            bad++;
            $display("FAIL pending_draw: got no draw pixel in 200 cycles, required one");
        end
        pulse(0);
        pulse(0);
        wait_drain("pending");
        repeat (150) @(negedge clk);
        check_step("pending", 3);
    endtask

    task automatic test_pause();
        @(posedge clk) #1 pause = 1;
        pulse(0);
        repeat (60) @(negedge clk);
        check_step("pause_hold", 3);
        push_frame(3, 0);
        push_frame(4, 1);
        @(posedge clk) #1 pause = 0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (pv !== 0) begin
            bad++;
            $display("FAIL pause_load: got valid=%0d, required 0", pv);
        end
        @(negedge clk);
        total++;
        if (pv !== 1 || pc !== 0) begin
            bad++;
            $display("FAIL pause_erase: got valid=%0d color=%0d, required 1 0", pv, pc);
        end
        wait_drain("pause");
        check_step("pause", 4);
    endtask

    task automatic test_steps(input int which, input int count);
        for (int i = 0; i < count; i++) begin
            int n;
            logic f;
            pulse(which);
            n = 0;
            f = 0;
            while (!f && n < 200) begin
                @(negedge clk);
                f = which == 1 ? fdb : fdw;
                n++;
            end
            total++;
            if (!f) begin
                bad++;
                $display("FAIL steps%0d_timeout: got no frame_done in 200 cycles, required one", which);
            end
            total++;
            if (which == 1 && int'(stepb) != exp_b[i]) begin
                bad++;
                $display("FAIL bounce_step[%0d]: got %0d, required %0d", i, stepb, exp_b[i]);
            end else if (which == 2 && int'(stepw) != exp_w[i]) begin
                bad++;
                $display("FAIL wrap_step[%0d]: got %0d, required %0d", i, stepw, exp_w[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_erase();
        int n, seen;
        push_frame(4, 0);
        pulse(0);
        n = 0;
        seen = 0;
        while (seen < 5 && n < 200) begin
            @(negedge clk);
            if (pv) seen++;
            n++;
        end
        total++;
        if (seen < 5) begin
            bad++;
            $display("FAIL midreset_erase: got %0d erase pixels, required 5", seen);
        end
        @(posedge clk) #1 reset = 1;
        q.delete();
        @(negedge clk);
        total++;
        if (pv !== 0) begin
            bad++;
            $display("FAIL midreset_valid: got %0d, required 0", pv);
        end
        @(negedge clk);
        check_step("midreset", 0);
        push_frame(0, 1);
        @(posedge clk) #1 reset = 0;
        wait_drain("midreset");
        check_step("midreset_redraw", 0);
    endtask

    initial begin
        test_reset();
        test_update();
        test_pending();
        test_pause();
        test_steps(1, 8);
        test_steps(2, 4);
        test_reset_mid_erase();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_line_animator.md
MULTI_LINE_ANIMATOR -- requirements
Module: multi_line_animator

Interface
REQ-001 Parameter W, default 11, coordinate width in bits.
REQ-002 Parameter N_LINES, default 2, number of lines animated per frame; legal range 1..8.
REQ-003 Parameter LINE_SPACING, default 20, y offset between consecutive lines.
REQ-004 Parameter LEN_X / LEN_Y, defaults 10 / 15, line extent from start to end point.
REQ-005 Parameter STEPS, default 128, number of animation positions; legal range 2..2^W-1.
REQ-006 Parameter BOUNCE, default 0; 0 = wrap mode, 1 = ping-pong mode.
REQ-007 clk  input  1  clock; all logic SHALL be on posedge clk.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 update_event  input  1  one-cycle request to advance the animation, synchronous to clk.
REQ-010 pause  input  1  while high, the block SHALL NOT start an erase from HOLD.
REQ-011 x, y  output  W  pixel coordinates; meaningful only when pixel_valid=1.
REQ-012 pixel_color  output  1  1 = white (draw), 0 = black (erase).
REQ-013 pixel_valid  output  1  (x,y,pixel_color) is a pixel to write this cycle.
REQ-014 frame_done  output  1  one-cycle pulse on the last pixel of the last line drawn.
REQ-015 step  output  8..W  current animation position, registered.

Function
REQ-016 The block SHALL instantiate line_drawer and reload it by asserting its reset for exactly one cycle per line.
REQ-017 Line k geometry: x0=step, y0=step+k*LINE_SPACING, x1=x0+LEN_X, y1=y0+LEN_Y; all sums SHALL be W bits, truncated modulo 2^W.
REQ-018 A line SHALL be complete when pixel_valid=1 and (x,y)==(x1,y1).
REQ-019 FSM states: LOAD_DRAW, DRAW, HOLD, LOAD_ERASE, ERASE.
REQ-020 LOAD_DRAW / LOAD_ERASE: drawer reset=1, pixel_valid=0; next state SHALL be DRAW / ERASE respectively.
REQ-021 DRAW: pixel_valid=1, pixel_color=1.
REQ-022 DRAW line-complete, line<N_LINES-1: line index +1, go to LOAD_DRAW.
REQ-023 DRAW line-complete, last line: line index=0, frame_done=1 that cycle, go to HOLD.
REQ-024 HOLD: pixel_valid=0; if (update_event|pending)&&!pause, clear pending and go to LOAD_ERASE; otherwise stay.
REQ-025 ERASE: pixel_valid=1, pixel_color=0; redraws the same lines at the same step.
REQ-026 ERASE line-complete, line<N_LINES-1: line index +1, go to LOAD_ERASE.
REQ-027 ERASE line-complete, last line: line index=0, update step, go to LOAD_DRAW.
REQ-028 An update_event outside HOLD, or in HOLD while pause=1, SHALL set a sticky pending flag.
REQ-029 Multiple events while pending=1 SHALL collapse into one; each erase consumes exactly one event.
REQ-030 Wrap mode: step SHALL advance step+1, with STEPS-1 -> 0.
REQ-031 Ping-pong mode: direction up steps +1 and at STEPS-1 reverses to STEPS-2.
REQ-032 Ping-pong mode: direction down steps -1 and at 0 reverses to 1.
REQ-033 pixel_color SHALL be 0 in all non-DRAW states.

Reset
REQ-034 reset SHALL force: state=LOAD_DRAW, step=0, line index=0, direction=up, pending=0.
REQ-035 reset SHALL force pixel_valid=0, pixel_color=0, frame_done=0; x,y are don't-care.
REQ-036 Reset mid-draw or mid-erase SHALL abort immediately with no cleanup erase.
REQ-037 reset SHALL take priority over update_event in the same cycle.

Verification
REQ-038 N_LINES=1, reset then idle -> 16 valid white pixels, first (0,0), last (10,15); frame_done once; stays HOLD.
REQ-039 Defaults, update_event in HOLD -> 2 erase lines at step 0 (black); step=1; redraw line0 (1,1)-(11,16) and line1 (1,21)-(11,36).
REQ-040 update_event pulsed twice during DRAW -> exactly one erase/redraw cycle after HOLD; pending then 0.
REQ-041 STEPS=4, BOUNCE=1, 8 updates -> step sequence 1,2,3,2,1,0,1,2.
REQ-042 STEPS=4, BOUNCE=0, 4 updates -> step sequence 1,2,3,0.
REQ-043 pause=1 with update_event in HOLD -> stays HOLD; on pause=0 -> LOAD_ERASE next cycle.
REQ-044 reset asserted mid-ERASE -> pixel_valid=0 next cycle; redraw restarts at (0,0), step=0.
